wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_pkg.sv | 18 +
 rtl/regfile_32x32.sv | 43 ++++
 rtl/wb_regfile.sv | 87 ++++++++
 tb/tb_wb_regfile.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - write-back stage encodings and register file constants
//
// Shared by wb_regfile and regfile_32x32.
// Optional feature macro consumed by wb_regfile: WB_BYPASS_EN.
package wb_pkg;

    // Write-back source select encodings; 2'b11 is reserved and behaves as ALU.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

endpackage

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 32-entry register storage, 1 write / 2 read ports, x0 hardwired to zero
//
// Ports:
//   clk        in   clock, write on rising edge
//   reset      in   asynchronous active-high reset, clears x1..x31
//   we         in   write enable (ignored when wa == 0)
//   wa         in   write address
//   wd         in   write data
//   ra1, ra2   in   read addresses
//   rd1, rd2   out  combinational read data, 0 for address 0
module regfile_32x32
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    // x0 has no storage at all.
    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, register file wrapper and write-commit counter
//
// Optional feature macro: WB_BYPASS_EN (same-cycle write-to-read bypass).
//
// Ports:
//   clk                  in   clock
//   reset                in   asynchronous active-high reset
//   wb_sel               in   write-back source select (wb_sel_e)
//   reg_wr               in   write enable of the retiring instruction
//   alu_result           in   ALU result
//   read_data            in   load data
//   rd                   in   destination register index
//   pc4                  in   PC+4 of the retiring instruction
//   rs1_addr, rs2_addr   in   read addresses
//   rs1_data, rs2_data   out  read data
//   wb_data              out  selected write-back value (combinational)
//   wr_count             out  committed register writes since reset (wrapping)
module wb_regfile
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        wb_sel,
    input  logic              reg_wr,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   read_data,
    input  logic [REG_AW-1:0] rd,
    input  logic [XLEN-1:0]   pc4,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   wb_data,
    output logic [CNT_W-1:0]  wr_count
);

    logic            commit;
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;

    always_comb begin
        wb_data = alu_result;
        case (wb_sel_e'(wb_sel))
            WB_MEM:  wb_data = read_data;
            WB_PC4:  wb_data = pc4;
            default: wb_data = alu_result;
        endcase
    end

    // Writes to x0 are dropped entirely: no storage update and no count.
    assign commit = reg_wr && (rd != '0);

    regfile_32x32 #(
        .XLEN (XLEN)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (commit),
        .wa    (rd),
        .wd    (wb_data),
        .ra1   (rs1_addr),
        .ra2   (rs2_addr),
        .rd1   (stored1),
        .rd2   (stored2)
    );

`ifdef WB_BYPASS_EN
    // commit already excludes rd == 0, so x0 reads stay zero.
    assign rs1_data = (commit && (rs1_addr == rd)) ? wb_data : stored1;
    assign rs2_data = (commit && (rs2_addr == rd)) ? wb_data : stored2;
`else
    assign rs1_data = stored1;
    assign rs2_data = stored2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
//
// Two instances share all inputs: dut (default widths) and dut4 (CNT_W=4)
// whose counter is used to observe wrap-around.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wb_sel;
    logic        reg_wr;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic [31:0] wr_count;
    logic [31:0] rs1_data4;
    logic [31:0] rs2_data4;
    logic [31:0] wb_data4;
    logic [3:0]  wr_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .wb_sel     (wb_sel),
        .reg_wr     (reg_wr),
        .alu_result (alu_result),
        .read_data  (read_data),
        .rd         (rd),
        .pc4        (pc4),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_data    (wb_data),
        .wr_count   (wr_count)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .wb_sel     (wb_sel),
        .reg_wr     (reg_wr),
        .alu_result (alu_result),
        .read_data  (read_data),
        .rd         (rd),
        .pc4        (pc4),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data4),
        .rs2_data   (rs2_data4),
        .wb_data    (wb_data4),
        .wr_count   (wr_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bypass_exp;

        reset = 1'b1; wb_sel = 2'b00; reg_wr = 1'b0; alu_result = '0; read_data = '0;
        rd = '0; pc4 = '0; rs1_addr = 5'd5; rs2_addr = 5'd31;
        #2;
        chk("reset_rs1_x5", rs1_data, 32'h0);
        chk("reset_rs2_x31", rs2_data, 32'h0);
        chk("reset_count", wr_count, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // ALU write to x5; first edge after reset must accept it
        wb_sel = 2'b00; alu_result = 32'h0000_1234; read_data = 32'h1111_1111; pc4 = 32'h2222_2222;
        rd = 5'd5; reg_wr = 1'b1;
        #1;
        chk("wbsel_alu", wb_data, 32'h0000_1234);
        tick();
        reg_wr = 1'b0; rs1_addr = 5'd5;
        #1;
        chk("x5_after_write", rs1_data, 32'h0000_1234);
        chk("count_after_x5", wr_count, 32'd1);

        // memory load to x7
        wb_sel = 2'b01; read_data = 32'hDEAD_BEEF; rd = 5'd7; reg_wr = 1'b1;
        #1;
        chk("wbsel_mem", wb_data, 32'hDEAD_BEEF);
        tick();
        reg_wr = 1'b0; rs2_addr = 5'd7;
        #1;
        chk("x7_mem_load", rs2_data, 32'hDEAD_BEEF);
        chk("count_after_x7", wr_count, 32'd2);

        // reserved select behaves as ALU; PC+4 select
        wb_sel = 2'b11; alu_result = 32'h0000_A5A5;
        #1;
        chk("wbsel_rsvd", wb_data, 32'h0000_A5A5);
        wb_sel = 2'b10; pc4 = 32'h0000_0404;
        #1;
        chk("wbsel_pc4", wb_data, 32'h0000_0404);

        // write to x0 is discarded, no bypass onto x0 in the same cycle
        wb_sel = 2'b00; alu_result = 32'hFFFF_FFFF; rd = 5'd0; reg_wr = 1'b1;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        chk("x0_same_cycle", rs1_data, 32'h0);
        tick();
        reg_wr = 1'b0;
        #1;
        chk("x0_after_write", rs1_data, 32'h0);
        chk("count_x0_unchanged", wr_count, 32'd2);

        // reg_wr=0 leaves x9 and count alone
        alu_result = 32'h0000_0055; rd = 5'd9; reg_wr = 1'b0; rs1_addr = 5'd9;
        tick();
        chk("x9_no_write", rs1_data, 32'h0);
        chk("count_no_write", wr_count, 32'd2);

        // preload x3, then same-cycle read of a PC+4 write to x3
        wb_sel = 2'b00; alu_result = 32'h0000_0077; rd = 5'd3; reg_wr = 1'b1;
        tick();
        wb_sel = 2'b10; pc4 = 32'h0000_0100; rd = 5'd3; reg_wr = 1'b1;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
`ifdef WB_BYPASS_EN
        bypass_exp = 32'h0000_0100;
`else
        bypass_exp = 32'h0000_0077;
`endif
        chk("x3_same_cycle_rs1", rs1_data, bypass_exp);
        chk("x3_same_cycle_rs2", rs2_data, bypass_exp);
        tick();
        reg_wr = 1'b0;
        #1;
        chk("x3_next_rs1", rs1_data, 32'h0000_0100);
        chk("x3_next_rs2", rs2_data, 32'h0000_0100);
        chk("count_after_x3", wr_count, 32'd4);

        // asynchronous reset mid-cycle, then a write held across an edge under reset
        rs1_addr = 5'd5;
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_x5", rs1_data, 32'h0);
        chk("async_reset_count", wr_count, 32'h0);
        wb_sel = 2'b00; alu_result = 32'h0000_0999; rd = 5'd5; reg_wr = 1'b1;
        tick();
        reg_wr = 1'b0;
        #1;
        chk("write_during_reset_x5", rs1_data, 32'h0);
        chk("write_during_reset_cnt", wr_count, 32'h0);
        reset = 1'b0;
        #1;

        // first edge after release accepts a write
        alu_result = 32'h0000_0042; rd = 5'd5; reg_wr = 1'b1;
        tick();
        reg_wr = 1'b0;
        #1;
        chk("x5_post_reset", rs1_data, 32'h0000_0042);
        chk("count_post_reset", wr_count, 32'd1);

        // 15 more commits: 16 total since reset, CNT_W=4 wraps to 0
        for (int i = 1; i <= 15; i++) begin
            alu_result = 32'h1000 + i; rd = 5'(i + 10); reg_wr = 1'b1;
            tick();
            if (i == 14) begin
                chk("count4_at_15", {28'h0, wr_count4}, 32'd15);
            end
        end
        reg_wr = 1'b0; rs2_addr = 5'd25;
        #1;
        chk("count4_wrap", {28'h0, wr_count4}, 32'd0);
        chk("count32_at_16", wr_count, 32'd16);
        chk("x25_last_write", rs2_data, 32'h0000_100F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
